// File: rtl/sseg_scan.sv
// Time-multiplexed seven-segment scanner driving a shared active-low an/sseg bus.
// Display data is double-buffered and only switches at frame boundaries.
module sseg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 500
) (
  input  logic                    clk,
  input  logic                    nRESET,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic                    pending,
  output logic                    frame_sync,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           slot_cnt;
  logic [IW-1:0]           dig_idx;
  logic                    slot_last;
  logic                    boundary;
  logic                    in_guard;

  logic [4*NUM_DIGITS-1:0] sh_value, act_value;
  logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
  logic                    sh_blz, act_blz;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    acc_zero;
  logic [3:0]              nibble;
  logic                    blanked;

  assign slot_last = (slot_cnt == CW'(REFRESH_DIV - 1));
  assign boundary  = slot_last && (dig_idx == IW'(NUM_DIGITS - 1));

  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (slot_cnt < CW'(GUARD));
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // zero_from[i] is set when every nibble from the top digit down to i is zero.
  always_comb begin
    zero_from = '0;
    acc_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc_zero     = acc_zero & (act_value[4*i +: 4] == 4'h0);
      zero_from[i] = acc_zero;
    end
  end

  assign nibble  = act_value[{dig_idx, 2'b00} +: 4];
  assign blanked = act_blz && (dig_idx != '0) && zero_from[dig_idx];

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      dig_idx  <= (dig_idx == IW'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // load is a one-cycle strobe with no back-pressure; a load in the boundary
  // cycle wins over the pending clear so the new data waits one more frame.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blz    <= 1'b0;
      pending    <= 1'b0;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= boundary;
      if (boundary && pending) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_blz   <= sh_blz;
      end
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_blz   <= blank_lz;
        pending  <= 1'b1;
      end else if (boundary) begin
        pending  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else if (in_guard) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= ~(NUM_DIGITS'(1) << dig_idx);
      sseg <= {~act_dp[dig_idx], blanked ? 7'h7F : hex7(nibble)};
    end
  end

endmodule
